// File: rtl/accel_display_ctrl.sv
// Accelerometer LED display: per-channel live / block-average / peak-hold views, one muxed onto o_led.
// Optional LED_BAR_EN: o_led shows a magnitude thermometer bar instead of the raw 2's complement value.

module accel_display_lane #(
   parameter int DATA_W   = 10,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic              blk_end_i,
   input  logic              clr_peak_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic [DATA_W-1:0] live_o,
   output logic [DATA_W-1:0] avg_o,
   output logic [DATA_W-1:0] peak_o
);
   localparam int ACC_W = DATA_W + AVG_LOG2;

   logic signed [ACC_W-1:0] acc_q, acc_d, sum;
   logic [DATA_W-1:0]       live_q, live_d, avg_q, avg_d, peak_q, peak_d;

   // One extra bit so the most negative sample has a representable magnitude
   function automatic logic [DATA_W:0] mag(input logic [DATA_W-1:0] v);
      logic [DATA_W:0] x;
      x = {v[DATA_W-1], v};
      return x[DATA_W] ? (~x + 1'b1) : x;
   endfunction

   assign sum = acc_q + ACC_W'($signed(sample_i));

   always_comb begin
      live_d = live_q;
      avg_d  = avg_q;
      acc_d  = acc_q;
      peak_d = peak_q;
      if (clr_peak_i) peak_d = '0;
      if (valid_i) begin
         live_d = sample_i;
         if (blk_end_i) begin
            avg_d = DATA_W'(sum >>> AVG_LOG2);
            acc_d = '0;
         end else begin
            acc_d = sum;
         end
         if (clr_peak_i || (mag(sample_i) > mag(peak_q))) peak_d = sample_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= '0;
         avg_q  <= '0;
         acc_q  <= '0;
         peak_q <= '0;
      end else begin
         live_q <= live_d;
         avg_q  <= avg_d;
         acc_q  <= acc_d;
         peak_q <= peak_d;
      end
   end

   assign live_o = live_q;
   assign avg_o  = avg_q;
   assign peak_o = peak_q;
endmodule

module accel_display_ctrl #(
   parameter int NUM_CH   = 3,
   parameter int DATA_W   = 10,
   parameter int AVG_LOG2 = 2
) (
   input  logic                     MAX10_CLK1_50,
   input  logic                     KEY1,
   input  logic [NUM_CH*DATA_W-1:0] i_data,
   input  logic                     i_data_valid,
   input  logic [NUM_CH-1:0]        i_sel,
   input  logic [1:0]               i_mode,
   input  logic                     i_clr_peak,
   output logic [DATA_W-1:0]        o_led,
   output logic                     o_avg_valid
);
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW    = DATA_W + 1 + $clog2(DATA_W + 1);

   logic [NUM_CH-1:0][DATA_W-1:0] live, avg, peak;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              blk_end;
   logic              avg_vld_q, avg_vld_d;
   logic [DATA_W-1:0] led_q, led_d, view;
   logic [SEL_W-1:0]  sel_idx;
   logic              sel_onehot;

   // With AVG_LOG2 == 0 the terminal count is 0, so every sample closes a block
   assign blk_end   = (cnt_q == CNT_W'((1 << AVG_LOG2) - 1));
   assign cnt_d     = !i_data_valid ? cnt_q : (blk_end ? '0 : cnt_q + 1'b1);
   assign avg_vld_d = i_data_valid & blk_end;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      accel_display_lane #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_lane (
         .clk        (MAX10_CLK1_50),
         .rst_n      (KEY1),
         .valid_i    (i_data_valid),
         .blk_end_i  (blk_end),
         .clr_peak_i (i_clr_peak),
         .sample_i   (i_data[c*DATA_W +: DATA_W]),
         .live_o     (live[c]),
         .avg_o      (avg[c]),
         .peak_o     (peak[c])
      );
   end

   // Invalid selections (none or several switches) fall back to channel 0
   assign sel_onehot = (i_sel != '0) && ((i_sel & (i_sel - 1'b1)) == '0);

   always_comb begin
      sel_idx = '0;
      if (sel_onehot)
         for (int c = 0; c < NUM_CH; c++)
            if (i_sel[c]) sel_idx = SEL_W'(c);
   end

   always_comb begin
      case (i_mode)
         2'b01:   view = avg[sel_idx];
         2'b10:   view = peak[sel_idx];
         default: view = live[sel_idx];
      endcase
   end

`ifdef LED_BAR_EN
   logic [DATA_W:0] vmag;
   logic [PW-1:0]   bar_n;
   logic [DATA_W-1:0] bar;

   always_comb begin
      logic [DATA_W:0] x;
      x     = {view[DATA_W-1], view};
      vmag  = x[DATA_W] ? (~x + 1'b1) : x;
      bar_n = (PW'(vmag) * PW'(DATA_W)) >> (DATA_W - 1);
      if (bar_n > PW'(DATA_W)) bar_n = PW'(DATA_W);
      for (int i = 0; i < DATA_W; i++) bar[i] = (PW'(i) < bar_n);
   end

   assign led_d = (i_mode == 2'b11) ? led_q : bar;
`else
   assign led_d = (i_mode == 2'b11) ? led_q : view;
`endif

   always_ff @(posedge MAX10_CLK1_50 or negedge KEY1) begin
      if (!KEY1) begin
         cnt_q     <= '0;
         avg_vld_q <= 1'b0;
         led_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         avg_vld_q <= avg_vld_d;
         led_q     <= led_d;
      end
   end

   assign o_led       = led_q;
   assign o_avg_valid = avg_vld_q;
endmodule

// File: tb/tb_accel_display_ctrl.sv
// Directed self-checking bench for accel_display_ctrl (default parameters, either LED_BAR_EN build).
`timescale 1ns/1ps
module tb_accel_display_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] data = '0;
   logic        valid = 1'b0;
   logic [2:0]  sel = 3'b001;
   logic [1:0]  mode = 2'b00;
   logic        clr = 1'b0;
   logic [9:0]  led;
   logic        avg_vld;

   int n_chk = 0;
   int n_fail = 0;

   accel_display_ctrl #(.NUM_CH(3), .DATA_W(10), .AVG_LOG2(2)) dut (
      .MAX10_CLK1_50 (clk),
      .KEY1          (rst_n),
      .i_data        (data),
      .i_data_valid  (valid),
      .i_sel         (sel),
      .i_mode        (mode),
      .i_clr_peak    (clr),
      .o_led         (led),
      .o_avg_valid   (avg_vld)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected LED pattern for a selected value
   function automatic logic [9:0] disp(input logic [9:0] v);
`ifdef LED_BAR_EN
      int a, n;
      a = v[9] ? 1024 - int'(v) : int'(v);
      n = (a * 10) >> 9;
      if (n > 10) n = 10;
      return 10'((1 << n) - 1);
`else
      return v;
`endif
   endfunction

   function automatic logic [29:0] pk(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
      return {c2, c1, c0};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Valid for one cycle; returns at the negedge right after the capture edge
   task automatic send(input logic [29:0] d, input logic c = 1'b0);
      @(negedge clk);
      data = d; valid = 1'b1; clr = c;
      @(negedge clk);
      valid = 1'b0; clr = 1'b0;
   endtask

   initial begin
      // reset state
      tick(2);
      chk("rst_led", led, 0);
      chk("rst_avgv", avg_vld, 0);
      rst_n = 1'b1;

      // live path, then async reset in the middle of a block
      mode = 2'b00; sel = 3'b010;
      send(pk(0, 10'd100, 0));
      send(pk(0, 10'd100, 0));
      tick(1);
      chk("pre_rst_live", led, disp(10'd100));
      #3 rst_n = 1'b0;
      #2;
      chk("midrst_led", led, 0);
      chk("midrst_avgv", avg_vld, 0);
      @(negedge clk) rst_n = 1'b1;

      // block average: 4,8,-4,12 -> 5 ; -1,-1,-1,-2 -> -2
      mode = 2'b01;
      send(pk(0, 10'd4, 0));
      send(pk(0, 10'd8, 0));
      chk("avgv_early", avg_vld, 0);
      send(pk(0, 10'h3FC, 0));
      chk("avgv_3rd", avg_vld, 0);
      send(pk(0, 10'd12, 0));
      chk("avgv_pulse", avg_vld, 1);
      tick(1);
      chk("avgv_once", avg_vld, 0);
      chk("avg_pos", led, disp(10'd5));
      send(pk(0, 10'h3FF, 0));
      send(pk(0, 10'h3FF, 0));
      send(pk(0, 10'h3FF, 0));
      send(pk(0, 10'h3FE, 0));
      chk("avgv_pulse2", avg_vld, 1);
      tick(1);
      chk("avg_neg", led, disp(10'h3FE));

      // live view and channel select
      mode = 2'b00; sel = 3'b001;
      send(pk(10'h155, 10'h0C3, 10'h2AA));
      tick(1);
      chk("live_ch0", led, disp(10'h155));
      sel = 3'b100; tick(1);
      chk("sel_ch2", led, disp(10'h2AA));
      sel = 3'b011; tick(1);
      chk("sel_multi", led, disp(10'h155));
      sel = 3'b010; tick(1);
      chk("sel_ch1", led, disp(10'h0C3));
      sel = 3'b000; tick(1);
      chk("sel_none", led, disp(10'h155));

      // peak hold on ch2
      mode = 2'b10; sel = 3'b100;
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      tick(1);
      chk("pk_clr", led, 0);
      send(pk(0, 0, 10'd100)); tick(1);
      chk("pk_100", led, disp(10'd100));
      send(pk(0, 0, 10'h2D4)); tick(1);
      chk("pk_m300", led, disp(10'h2D4));
      send(pk(0, 0, 10'd200)); tick(1);
      chk("pk_200", led, disp(10'h2D4));
      send(pk(0, 0, 10'h2D4)); tick(1);
      chk("pk_tie_same", led, disp(10'h2D4));
      send(pk(0, 0, 10'd300)); tick(1);
      chk("pk_tie_pos", led, disp(10'h2D4));
      send(pk(0, 0, 10'd7), 1'b1); tick(1);
      chk("pk_clr_smp", led, disp(10'd7));
      send(pk(0, 0, 10'h200)); tick(1);
      chk("pk_min", led, disp(10'h200));
      send(pk(0, 0, 10'h1FF)); tick(1);
      chk("pk_max_lt", led, disp(10'h200));

      // freeze
      mode = 2'b00; sel = 3'b001;
      send(pk(10'h155, 0, 0)); tick(1);
      chk("frz_pre", led, disp(10'h155));
      mode = 2'b11;
      send(pk(10'd1, 0, 0));
      send(pk(10'd2, 0, 0));
      send(pk(10'd3, 0, 0));
      tick(1);
      chk("frz_hold", led, disp(10'h155));
      mode = 2'b00;
      tick(1);
      chk("frz_release", led, disp(10'd3));

      // magnitude boundaries (bar pattern in LED_BAR_EN builds)
      send(pk(10'h200, 0, 0)); tick(1);
      chk("b_m512", led, disp(10'h200));
      send(pk(10'd255, 0, 0)); tick(1);
      chk("b_255", led, disp(10'd255));
      send(pk(10'd0, 0, 0)); tick(1);
      chk("b_0", led, disp(10'd0));
      send(pk(10'd511, 0, 0)); tick(1);
      chk("b_511", led, disp(10'd511));
`ifdef LED_BAR_EN
      send(pk(10'h200, 0, 0)); tick(1);
      chk("bar_m512", led, 10'h3FF);
      send(pk(10'd255, 0, 0)); tick(1);
      chk("bar_255", led, 10'h00F);
      send(pk(10'd511, 0, 0)); tick(1);
      chk("bar_511", led, 10'h1FF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
